// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the unified-RAM memory controller: FSM state
// encodings, MEM access length codes and the default RAM address width.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        MC_IDLE   = 2'd0,
        MC_IF_RD  = 2'd1,
        MC_MEM_RD = 2'd2,
        MC_MEM_WR = 2'd3
    } mc_state_e;

    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_W = 2'd2;

    localparam int RAM_ADDRESS_SIZE = 17;

    // Byte count for a MEM length code; the unused code 3 behaves as a word.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_B:   return 3'd1;
            LEN_H:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates the byte-wide unified RAM port between
// instruction fetch and the MEM stage, sequencing multi-byte little-endian
// accesses as back-to-back byte cycles.
// Optional build macro MEM_CTRL_PERF_EN adds per-requester stall-cycle
// counters (perf_if_cyc, perf_mem_cyc).
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int RAM_AW = RAM_ADDRESS_SIZE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic              stall_req_if,
    output logic              stall_req_mem
`ifdef MEM_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_if_cyc,
    output logic [31:0]       perf_mem_cyc
`endif
);

    mc_state_e         state, state_d;
    logic [2:0]        cnt;
    logic [2:0]        cnt_nxt;
    logic [2:0]        cnt_prev;
    logic [2:0]        nbytes;
    logic [RAM_AW-1:0] base;
    logic [RAM_AW-1:0] next_addr;
    logic [31:0]       wdata_q;
    logic [31:0]       asm_q;
    logic [31:0]       asm_nxt;
    logic              grant_mem;
    logic              grant_if;
    logic              rd_last;
    logic              wr_last;

    // Only the low RAM_AW address bits reach the RAM.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{if_addr[ADDR_W-1:RAM_AW], mem_addr[ADDR_W-1:RAM_AW]};

    assign stall_req_if  = if_req  & ~if_done;
    assign stall_req_mem = mem_req & ~mem_done;

    // A requester whose done is high this cycle is not re-granted; MEM wins ties.
    assign grant_mem = mem_req & ~mem_done;
    assign grant_if  = if_req & ~if_done & ~grant_mem;

    assign cnt_nxt  = cnt + 3'd1;
    assign cnt_prev = cnt - 3'd1;
    // Offset arithmetic is modulo 2^RAM_AW, so accesses wrap at the top of RAM.
    assign next_addr = base + {{(RAM_AW-3){1'b0}}, cnt_nxt};
    // Reads: cnt counts cycles since the first address; byte cnt-1 arrives now.
    assign rd_last  = (cnt == nbytes);
    // Writes: cnt is the byte being driven this cycle.
    assign wr_last  = (cnt_nxt == nbytes);

    // Merge the byte arriving this cycle into the assembly buffer.
    always_comb begin
        asm_nxt = asm_q;
        asm_nxt[{cnt_prev[1:0], 3'b000} +: 8] = ram_din;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= MC_IDLE;
        else     state <= state_d;
    end

    // Next-state logic; grants are non-preemptive.
    always_comb begin
        state_d = state;
        case (state)
            MC_IDLE: begin
                if (grant_mem)     state_d = mem_we ? MC_MEM_WR : MC_MEM_RD;
                else if (grant_if) state_d = MC_IF_RD;
            end
            MC_IF_RD, MC_MEM_RD: if (rd_last) state_d = MC_IDLE;
            MC_MEM_WR:           if (wr_last) state_d = MC_IDLE;
            default:             state_d = MC_IDLE;
        endcase
    end

    // Datapath: latch the request at grant, walk the byte sequence, return data.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            nbytes    <= '0;
            base      <= '0;
            wdata_q   <= '0;
            asm_q     <= '0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            if_data   <= '0;
            mem_rdata <= '0;
            ram_addr  <= '0;
            ram_wr    <= 1'b0;
            ram_dout  <= '0;
        end else begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            case (state)
                MC_IDLE: begin
                    if (grant_mem) begin
                        base     <= mem_addr[RAM_AW-1:0];
                        nbytes   <= len_bytes(mem_len);
                        wdata_q  <= mem_wdata;
                        cnt      <= '0;
                        asm_q    <= '0;
                        ram_addr <= mem_addr[RAM_AW-1:0];
                        ram_wr   <= mem_we;
                        ram_dout <= mem_we ? mem_wdata[7:0] : 8'h00;
                    end else if (grant_if) begin
                        base     <= if_addr[RAM_AW-1:0];
                        nbytes   <= 3'd4;
                        cnt      <= '0;
                        asm_q    <= '0;
                        ram_addr <= if_addr[RAM_AW-1:0];
                    end
                end
                MC_IF_RD, MC_MEM_RD: begin
                    cnt <= cnt_nxt;
                    if (cnt != 3'd0)
                        asm_q <= asm_nxt;
                    if (cnt_nxt < nbytes)
                        ram_addr <= next_addr;
                    if (rd_last) begin
                        cnt <= '0;
                        if (state == MC_IF_RD) begin
                            if_done <= 1'b1;
                            if_data <= asm_nxt;
                        end else begin
                            mem_done  <= 1'b1;
                            mem_rdata <= asm_nxt;
                        end
                    end
                end
                MC_MEM_WR: begin
                    if (wr_last) begin
                        cnt      <= '0;
                        ram_wr   <= 1'b0;
                        mem_done <= 1'b1;
                    end else begin
                        cnt      <= cnt_nxt;
                        ram_addr <= next_addr;
                        ram_wr   <= 1'b1;
                        ram_dout <= wdata_q[{cnt_nxt[1:0], 3'b000} +: 8];
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_CTRL_PERF_EN
    // Saturating stall-cycle counters, one per requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_if_cyc  <= '0;
            perf_mem_cyc <= '0;
        end else begin
            if (stall_req_if && perf_if_cyc != 32'hFFFF_FFFF)
                perf_if_cyc <= perf_if_cyc + 32'd1;
            if (stall_req_mem && perf_mem_cyc != 32'hFFFF_FFFF)
                perf_mem_cyc <= perf_mem_cyc + 32'd1;
        end
    end
`endif

endmodule
